// File: rtl/rr_arbiter4_16bit_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_16bit_pkg
// Shared definitions for the four-way round-robin arbiter slice.
//   state_t      : arbiter FSM encoding (IDLE, OWN)
//   REQ_A..REQ_D : requester index constants (bit position in req/gnt)
//   DEF_WIDTH    : default data width of the shared bus
//   DEF_MAX_LOCK : default cap on consecutive locked transfers
//   onehot4()    : converts a requester index into a one-hot grant vector
// ---------------------------------------------------------------------------
package rr_arbiter4_16bit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic [1:0] REQ_A = 2'd0;
   localparam logic [1:0] REQ_B = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;
   localparam logic [1:0] REQ_D = 2'd3;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_MAX_LOCK = 8;

   // Turns a 2-bit requester index into the matching one-hot grant pattern.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4_16bit_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_16bit_if
// Bundles the request side and the consumer side of the arbiter.
//   req[3:0], lock[3:0]  : per-requester request and keep-ownership flags
//   InA..InD             : requester data words
//   rdy                  : consumer accepts Out this cycle when vld=1
//   Out, vld             : registered shared output word and its valid flag
//   gnt[3:0], sel[1:0]   : one-hot grant strobe and mux select
//   busy                 : arbiter is holding a locked owner
// Modports: master = requesters/consumer side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface rr_arbiter4_16bit_if #(
   parameter int WIDTH = 16
);

   logic [3:0]       req;
   logic [3:0]       lock;
   logic [WIDTH-1:0] InA;
   logic [WIDTH-1:0] InB;
   logic [WIDTH-1:0] InC;
   logic [WIDTH-1:0] InD;
   logic             rdy;
   logic [WIDTH-1:0] Out;
   logic             vld;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic             busy;

   modport master (
      output req, lock, InA, InB, InC, InD, rdy,
      input  Out, vld, gnt, sel, busy
   );

   modport slave (
      input  req, lock, InA, InB, InC, InD, rdy,
      output Out, vld, gnt, sel, busy
   );

endinterface

// File: rtl/rr_arbiter4_16bit_pick.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Rotate-priority encoder for four requesters.
//   req[3:0] : request vector
//   ptr[1:0] : index of the most recent winner (lowest priority next)
//   any      : at least one request is present
//   idx[1:0] : first set request scanning ptr+1, ptr+2, ... modulo 4
// ---------------------------------------------------------------------------
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] idx
);

   // Walk the four positions starting just after the last winner; the first
   // hit wins and later hits are ignored. The 2-bit add wraps naturally.
   always_comb begin
      any = 1'b0;
      idx = ptr;
      for (int k = 1; k <= 4; k++) begin
         logic [1:0] cand;
         cand = ptr + 2'(k);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter4_16bit.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_16bit
// Round-robin arbiter sharing one registered data bus between four
// requesters, with optional bounded locked ownership and ready/valid
// backpressure on the consumer side.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave modport of rr_arbiter4_16bit_if (req, lock, InA..InD, rdy
//          in; Out, vld, gnt, sel, busy out)
// Parameters: WIDTH (data width), MAX_LOCK (1..255 consecutive locked
// transfers before the lock request is ignored).
// ---------------------------------------------------------------------------
module rr_arbiter4_16bit
   import rr_arbiter4_16bit_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_LOCK = DEF_MAX_LOCK
) (
   input logic                   clk,
   input logic                   rst,
   rr_arbiter4_16bit_if.slave    bus
);

   state_t           state;
   state_t           nextState;
   logic [1:0]       ptr;
   logic [1:0]       owner;
   logic [1:0]       selQ;
   logic [1:0]       selC;
   logic [1:0]       winner;
   logic [1:0]       pickIdx;
   logic [7:0]       cnt;
   logic [WIDTH-1:0] outQ;
   logic [WIDTH-1:0] muxOut;
   logic [3:0]       gntC;
   logic             vldQ;
   logic             slot;
   logic             any;
   logic             capture;
   logic             exitOwn;

   rr_pick4 uPick (
      .req (bus.req),
      .ptr (ptr),
      .any (any),
      .idx (pickIdx)
   );

   // The output register can take a new word when it is empty or when the
   // consumer is draining the current one in this same cycle.
   assign slot = ~vldQ | bus.rdy;

   // The owner leaves OWN after this capture if it dropped its lock or if
   // this capture is the last one the cap allows.
   assign exitOwn = ~bus.lock[owner] | (cnt == 8'(MAX_LOCK - 1));

   // Grant decision and next state. Only state, ptr, req, lock, slot and rst
   // feed this block, so data inputs never reach gnt. Reset forces gnt low so
   // an ungranted requester keeps its word.
   always_comb begin
      capture   = 1'b0;
      winner    = pickIdx;
      nextState = state;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (slot && any) begin
                  capture = 1'b1;
                  winner  = pickIdx;
                  if (bus.lock[pickIdx] && (MAX_LOCK > 1)) begin
                     nextState = OWN;
                  end
               end
            end
            OWN: begin
               if (!bus.req[owner]) begin
                  nextState = IDLE;
               end else if (slot) begin
                  capture = 1'b1;
                  winner  = owner;
                  if (exitOwn) begin
                     nextState = IDLE;
                  end
               end
            end
            default: nextState = IDLE;
         endcase
      end
      gntC = capture ? onehot4(winner) : 4'b0000;
      selC = capture ? winner : selQ;
   end

   // Shared 4:1 data mux steered by the live select.
   always_comb begin
      case (selC)
         REQ_A:   muxOut = bus.InA;
         REQ_B:   muxOut = bus.InB;
         REQ_C:   muxOut = bus.InC;
         default: muxOut = bus.InD;
      endcase
   end

   // State, pointer, lock counter and output register. A capture loads the
   // word and moves the pointer to the winner; a free slot with no capture
   // empties the register; a stalled slot holds everything. Re-capture by a
   // locked owner leaves ptr at the owner, so others get priority on exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= REQ_D;
         owner <= REQ_A;
         cnt   <= 8'd0;
         selQ  <= REQ_A;
         outQ  <= '0;
         vldQ  <= 1'b0;
      end else begin
         state <= nextState;
         selQ  <= selC;
         if (capture) begin
            outQ <= muxOut;
            vldQ <= 1'b1;
            ptr  <= winner;
         end else if (slot) begin
            vldQ <= 1'b0;
         end
         if (state == IDLE && nextState == OWN) begin
            owner <= winner;
            cnt   <= 8'd1;
         end else if (state == OWN) begin
            if (nextState == IDLE) begin
               cnt <= 8'd0;
            end else if (capture) begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

   assign bus.Out  = outQ;
   assign bus.vld  = vldQ;
   assign bus.gnt  = gntC;
   assign bus.sel  = selC;
   assign bus.busy = (state == OWN);

endmodule

// File: tb/tb_rr_arbiter4_16bit.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4_16bit
// Self-checking bench for rr_arbiter4_16bit built with MAX_LOCK=3. Each
// table row is one clock cycle of inputs plus the expected grant, select,
// valid and busy seen in that cycle. Requester i drives base+i, so a grant
// pushes the expected word into a queue that is popped and compared against
// Out one cycle later.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4_16bit;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  lock;
      logic        rdy;
      logic        rst;
      logic [15:0] base;
      logic [3:0]  expGnt;
      logic [1:0]  expSel;
      logic        expVld;
      logic        expBusy;
      logic        outZero;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic capPrev;
   logic [15:0] heldExp;
   logic [15:0] expQ[$];
   vec_t vecs[$];

   rr_arbiter4_16bit_if #(.WIDTH(16)) bus ();

   rr_arbiter4_16bit #(.WIDTH(16), .MAX_LOCK(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(logic [3:0] req, logic [3:0] lock, logic rdy,
                               logic rstIn, logic [15:0] base,
                               logic [3:0] expGnt, logic [1:0] expSel,
                               logic expVld, logic expBusy, logic outZero);
      vec_t v;
      v.req = req;  v.lock = lock;  v.rdy = rdy;  v.rst = rstIn;
      v.base = base;  v.expGnt = expGnt;  v.expSel = expSel;
      v.expVld = expVld;  v.expBusy = expBusy;  v.outZero = outZero;
      return v;
   endfunction

   function automatic logic [1:0] idxOf(logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (oh[k]) r = 2'(k);
      end
      return r;
   endfunction

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      rst      = v.rst;
      bus.req  = v.req;
      bus.lock = v.lock;
      bus.rdy  = v.rdy;
      bus.InA  = v.base;
      bus.InB  = v.base + 16'd1;
      bus.InC  = v.base + 16'd2;
      bus.InD  = v.base + 16'd3;
   endtask

   task automatic checkOutput(vec_t v, int row);
      if (capPrev) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL row%0d scoreboard: queue empty", row);
         end else begin
            heldExp = expQ.pop_front();
         end
      end
      cmp($sformatf("row%0d gnt", row), 32'(bus.gnt), 32'(v.expGnt));
      cmp($sformatf("row%0d sel", row), 32'(bus.sel), 32'(v.expSel));
      cmp($sformatf("row%0d vld", row), 32'(bus.vld), 32'(v.expVld));
      cmp($sformatf("row%0d busy", row), 32'(bus.busy), 32'(v.expBusy));
      if (v.expVld) begin
         cmp($sformatf("row%0d Out", row), 32'(bus.Out), 32'(heldExp));
      end
      if (v.outZero) begin
         cmp($sformatf("row%0d Out after reset", row), 32'(bus.Out), 32'd0);
      end
      capPrev = (v.expGnt != 4'b0000) && !v.rst;
      if (capPrev) begin
         expQ.push_back(v.base + 16'(idxOf(v.expGnt)));
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      capPrev = 1'b0;
      heldExp = 16'd0;

      // Fair rotation: A,B,C,D,A then drain.
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h000A, 4'b0001, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h000A, 4'b0010, 2'd1, 1, 0, 0));
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h000A, 4'b0100, 2'd2, 1, 0, 0));
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h000A, 4'b1000, 2'd3, 1, 0, 0));
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h000A, 4'b0001, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h000A, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h000A, 4'b0000, 2'd0, 0, 0, 0));
      // Backpressure: Out held for 3 stalled cycles, then new word.
      vecs.push_back(mk(4'h1, 4'h0, 1, 0, 16'h1234, 4'b0001, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'h1, 4'h0, 0, 0, 16'h1234, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h1, 4'h0, 0, 0, 16'h1234, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h1, 4'h0, 0, 0, 16'h1234, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h1, 4'h0, 1, 0, 16'h5678, 4'b0001, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h5678, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h5678, 4'b0000, 2'd0, 0, 0, 0));
      // Lock cap of 3: a D grant first so A leads, then A,A,A,B.
      vecs.push_back(mk(4'h8, 4'h0, 1, 0, 16'h0100, 4'b1000, 2'd3, 0, 0, 0));
      vecs.push_back(mk(4'h3, 4'h1, 1, 0, 16'h0100, 4'b0001, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h3, 4'h1, 1, 0, 16'h0100, 4'b0001, 2'd0, 1, 1, 0));
      vecs.push_back(mk(4'h3, 4'h1, 1, 0, 16'h0100, 4'b0001, 2'd0, 1, 1, 0));
      vecs.push_back(mk(4'h3, 4'h1, 1, 0, 16'h0100, 4'b0010, 2'd1, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0100, 4'b0000, 2'd1, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0100, 4'b0000, 2'd1, 0, 0, 0));
      // Owner drop: C locks, then releases its request -> bubble, then B.
      vecs.push_back(mk(4'h4, 4'h4, 1, 0, 16'h0C00, 4'b0100, 2'd2, 0, 0, 0));
      vecs.push_back(mk(4'h4, 4'h4, 1, 0, 16'h0C00, 4'b0100, 2'd2, 1, 1, 0));
      vecs.push_back(mk(4'h2, 4'h0, 1, 0, 16'h0C00, 4'b0000, 2'd2, 1, 1, 0));
      vecs.push_back(mk(4'h2, 4'h0, 1, 0, 16'h0C00, 4'b0010, 2'd1, 0, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0C00, 4'b0000, 2'd1, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0C00, 4'b0000, 2'd1, 0, 0, 0));
      // Capture while consuming: D granted with vld=1 and rdy=1.
      vecs.push_back(mk(4'h1, 4'h0, 1, 0, 16'h0D00, 4'b0001, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'h8, 4'h0, 1, 0, 16'h0D00, 4'b1000, 2'd3, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0D00, 4'b0000, 2'd3, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0D00, 4'b0000, 2'd3, 0, 0, 0));
      // Reset while owning with a word held; A wins first afterwards.
      vecs.push_back(mk(4'h1, 4'h1, 1, 0, 16'h0E00, 4'b0001, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'h1, 4'h1, 1, 0, 16'h0E00, 4'b0001, 2'd0, 1, 1, 0));
      vecs.push_back(mk(4'hF, 4'h1, 1, 1, 16'h0E00, 4'b0000, 2'd0, 1, 1, 0));
      vecs.push_back(mk(4'hF, 4'h0, 1, 0, 16'h0E00, 4'b0001, 2'd0, 0, 0, 1));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0E00, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(mk(4'h0, 4'h0, 1, 0, 16'h0E00, 4'b0000, 2'd0, 0, 0, 0));

      // Power-on reset held for two edges with no requests.
      rst      = 1'b1;
      bus.req  = 4'h0;
      bus.lock = 4'h0;
      bus.rdy  = 1'b1;
      bus.InA  = 16'h0;
      bus.InB  = 16'h0;
      bus.InC  = 16'h0;
      bus.InD  = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      cmp("reset Out", 32'(bus.Out), 32'd0);
      cmp("reset vld", 32'(bus.vld), 32'd0);
      cmp("reset busy", 32'(bus.busy), 32'd0);
      cmp("reset gnt", 32'(bus.gnt), 32'd0);
      cmp("reset sel", 32'(bus.sel), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i], i);
      end

      @(negedge clk);
      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
